// File: rtl/best_weight_ctrl.sv
// best_weight_ctrl: sequences the weight memory through an iterative solve.
// Initial guesses are loaded (INIT), then every iteration reads the active
// weights (READ), waits for the iteration error (WAIT_ERR) and rewrites the
// active weights (SAVE) only when the error strictly improves on best_err.
// Every output is a register. A memory strobe therefore goes high in the
// cycle after the condition that requests it; in INIT this means mem_wr_en
// lags init_valid by one cycle, and the data path must align data_in to it.
// dbg_state exposes the FSM state to checkers.
module best_weight_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int EXTRA_BITS   = 2,
    parameter int NUM_UNKNOWNS = 4,
    parameter int RAM_DEPTH    = 8,
    parameter int ITER_WIDTH   = 16,
    localparam int ERR_WIDTH   = DATA_WIDTH + EXTRA_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ITER_WIDTH-1:0] max_iter,
    input  logic                  init_valid,
    input  logic                  err_valid,
    input  logic [ERR_WIDTH-1:0]  err_in,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic                  mem_update,
    output logic                  mem_init_flag,
    output logic [ERR_WIDTH-1:0]  best_err,
    output logic [ITER_WIDTH-1:0] iter_count,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic [2:0]            dbg_state
);

    localparam int CNT_W = $clog2(RAM_DEPTH + 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(RAM_DEPTH - 1);
    localparam logic [CNT_W-1:0] NUM_LAST  = CNT_W'(NUM_UNKNOWNS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT     = 3'd1,
        READ     = 3'd2,
        WAIT_ERR = 3'd3,
        SAVE     = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;       // writes issued in INIT, cycles in READ/SAVE
    logic [ITER_WIDTH-1:0] max_lim;   // latched iteration limit, 0 mapped to 1
    logic                  err_zero;  // the error that triggered SAVE was zero

    logic [ITER_WIDTH-1:0] iter_next;
    logic                  err_better;
    logic                  end_iter;
    logic                  end_zero;

    assign dbg_state = state;

    // End-of-iteration decode shared by the non-improving and SAVE exits
    always_comb begin
        iter_next  = (iter_count == '1) ? iter_count : iter_count + ITER_WIDTH'(1);
        err_better = (err_in < best_err);
        end_iter   = 1'b0;
        end_zero   = 1'b0;
        if (state == WAIT_ERR && err_valid && !err_better) begin
            end_iter = 1'b1;
            end_zero = (err_in == '0);
        end else if (state == SAVE && cnt == NUM_LAST) begin
            end_iter = 1'b1;
            end_zero = err_zero;
        end
    end

    // Control FSM with registered strobes and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            max_lim       <= '0;
            err_zero      <= 1'b0;
            mem_wr_en     <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_update    <= 1'b0;
            mem_init_flag <= 1'b0;
            best_err      <= '1;
            iter_count    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            converged     <= 1'b0;
        end else if (abort) begin
            // Drop everything but keep the status of the abandoned solve
            state         <= IDLE;
            cnt           <= '0;
            mem_wr_en     <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_update    <= 1'b0;
            mem_init_flag <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        max_lim       <= (max_iter == '0) ? ITER_WIDTH'(1) : max_iter;
                        iter_count    <= '0;
                        best_err      <= '1;
                        converged     <= 1'b0;
                        cnt           <= '0;
                        busy          <= 1'b1;
                        mem_init_flag <= 1'b1;
                        state         <= INIT;
                    end
                end
                INIT: begin
                    // cnt counts write pulses actually issued, so the last
                    // write finishes before the first read strobe
                    if (mem_wr_en && cnt == INIT_LAST) begin
                        mem_wr_en     <= 1'b0;
                        mem_init_flag <= 1'b0;
                        mem_rd_en     <= 1'b1;
                        cnt           <= '0;
                        state         <= READ;
                    end else begin
                        mem_wr_en <= init_valid;
                        if (mem_wr_en) cnt <= cnt + CNT_W'(1);
                    end
                end
                READ: begin
                    if (cnt == NUM_LAST) begin
                        mem_rd_en <= 1'b0;
                        cnt       <= '0;
                        state     <= WAIT_ERR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_ERR: begin
                    if (err_valid && err_better) begin
                        best_err   <= err_in;
                        err_zero   <= (err_in == '0);
                        mem_update <= 1'b1;
                        mem_wr_en  <= 1'b1;
                        cnt        <= '0;
                        state      <= SAVE;
                    end
                end
                SAVE: begin
                    if (cnt == NUM_LAST) begin
                        mem_update <= 1'b0;
                        mem_wr_en  <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (end_iter) begin
                iter_count <= iter_next;
                if (end_zero) begin
                    converged <= 1'b1;
                    done      <= 1'b1;
                    state     <= DONE;
                end else if (iter_next == max_lim) begin
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    mem_rd_en <= 1'b1;
                    state     <= READ;
                end
            end
        end
    end

endmodule

// File: tb/tb_best_weight_ctrl.sv
// Testbench for best_weight_ctrl: scenario tasks drive solves, a done-pulse
// monitor pops expected {best_err, iter_count, converged} from a queue, and
// strobe counters are compared per scenario against a small solve model.
module tb_best_weight_ctrl;

    localparam int DW = 32;
    localparam int EB = 2;
    localparam int EW = DW + EB;
    localparam int NU = 4;
    localparam int RD = 8;
    localparam int IW = 16;
    localparam int SB_W = EW + IW + 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_SAVE = 3'd4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [IW-1:0] max_iter = '0;
    logic          init_valid = 1'b0;
    logic          err_valid = 1'b0;
    logic [EW-1:0] err_in = '0;
    logic          mem_wr_en, mem_rd_en, mem_update, mem_init_flag;
    logic [EW-1:0] best_err;
    logic [IW-1:0] iter_count;
    logic          busy, done, converged;
    logic [2:0]    dbg_state;

    best_weight_ctrl #(
        .DATA_WIDTH(DW), .EXTRA_BITS(EB), .NUM_UNKNOWNS(NU),
        .RAM_DEPTH(RD), .ITER_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .max_iter(max_iter),
        .init_valid(init_valid), .err_valid(err_valid), .err_in(err_in),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_update(mem_update),
        .mem_init_flag(mem_init_flag), .best_err(best_err), .iter_count(iter_count),
        .busy(busy), .done(done), .converged(converged), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [SB_W-1:0] exp_q[$];
    logic [EW-1:0]   err_stim[$];
    logic [SB_W-1:0] sb_exp;

    int init_wr_cnt = 0, rd_cnt = 0, rd_bursts = 0, save_cnt = 0;
    int done_cnt = 0, overlap_cnt = 0;
    logic rd_prev = 1'b0;

    // Monitor: strobe counters and scoreboard pop on each done pulse
    always @(negedge clk) begin
        if (mem_wr_en && mem_init_flag) init_wr_cnt++;
        if (mem_rd_en) rd_cnt++;
        if (mem_rd_en && !rd_prev) rd_bursts++;
        rd_prev = mem_rd_en;
        if (mem_update && mem_wr_en) save_cnt++;
        if ((mem_update && mem_init_flag) || (mem_rd_en && mem_wr_en)) overlap_cnt++;
        if (done) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: got done with empty queue at %0t", $time);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({best_err, iter_count, converged} !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_result: got best=%0d iter=%0d conv=%0d want best=%0d iter=%0d conv=%0d",
                             best_err, iter_count, converged,
                             sb_exp[SB_W-1 -: EW], sb_exp[IW:1], sb_exp[0]);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [IW-1:0] mi);
        @(negedge clk);
        max_iter = mi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_init();
        for (int i = 0; i < RD; i++) begin
            init_valid = 1'b1;
            @(negedge clk);
            init_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (dbg_state !== s && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (dbg_state !== s) begin
            checks++;
            errors++;
            $display("FAIL %s wait_state: got state %0d want %0d (timeout)", tag, dbg_state, s);
        end
    endtask

    task automatic send_err(input logic [EW-1:0] e);
        err_in = e;
        err_valid = 1'b1;
        @(negedge clk);
        err_valid = 1'b0;
    endtask

    task automatic wait_done(input int snap, input string tag);
        int n = 0;
        while (done_cnt == snap && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == snap) begin
            checks++;
            errors++;
            $display("FAIL %s wait_done: got no done want done (timeout)", tag);
        end
    endtask

    task automatic chk(input string tag, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Full solve driven from err_stim; expectation from the model
    task automatic run_solve(input logic [IW-1:0] mi, input string tag);
        logic [EW-1:0] best = '1;
        int it = 0;
        logic conv = 1'b0;
        int nsave = 0;
        int lim = (mi == 0) ? 1 : int'(mi);
        int s_init, s_rd, s_burst, s_save, s_done;
        for (int i = 0; i < err_stim.size(); i++) begin
            if (err_stim[i] < best) begin
                best = err_stim[i];
                nsave++;
            end
            it++;
            if (err_stim[i] == 0) begin
                conv = 1'b1;
                break;
            end
            if (it == lim) break;
        end
        exp_q.push_back({best, IW'(it), conv});
        s_init = init_wr_cnt; s_rd = rd_cnt; s_burst = rd_bursts;
        s_save = save_cnt; s_done = done_cnt;
        do_start(mi);
        do_init();
        for (int i = 0; i < it; i++) begin
            wait_state(ST_WAIT, tag);
            send_err(err_stim[i]);
        end
        wait_done(s_done, tag);
        repeat (2) @(negedge clk);
        chk({tag, " init_writes"}, init_wr_cnt - s_init, RD);
        chk({tag, " read_cycles"}, rd_cnt - s_rd, NU * it);
        chk({tag, " read_bursts"}, rd_bursts - s_burst, it);
        chk({tag, " save_cycles"}, save_cnt - s_save, NU * nsave);
        chk({tag, " done_pulses"}, done_cnt - s_done, 1);
        chk({tag, " busy_after"}, busy, 0);
        chk({tag, " best_err"}, best_err, best);
        chk({tag, " iter_count"}, iter_count, it);
        chk({tag, " converged"}, converged, conv);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset state", dbg_state, ST_IDLE);
        chk("reset strobes", {mem_wr_en, mem_rd_en, mem_update, mem_init_flag}, 0);
        chk("reset status", {busy, done, converged}, 0);
        chk("reset best_err", best_err, {EW{1'b1}});
        chk("reset iter_count", iter_count, 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        err_stim = '{34'd10, 34'd5, 34'd7};
        run_solve(16'd3, "basic");
    endtask

    task automatic test_converge();
        err_stim = '{34'd9, 34'd0};
        run_solve(16'd5, "converge");
    endtask

    task automatic test_equal();
        err_stim = '{34'd6, 34'd6};
        run_solve(16'd2, "equal");
    endtask

    task automatic test_max_zero();
        err_stim = '{34'd42, 34'd1};
        run_solve(16'd0, "max_zero");
    endtask

    task automatic test_abort();
        int s_done = done_cnt;
        int s_save;
        do_start(16'd3);
        do_init();
        wait_state(ST_WAIT, "abort");
        s_save = save_cnt;
        send_err(34'd10);
        wait_state(ST_SAVE, "abort");
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        max_iter = 16'd7;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort state", dbg_state, ST_IDLE);
        chk("abort strobes", {mem_wr_en, mem_rd_en, mem_update, mem_init_flag}, 0);
        chk("abort busy", busy, 0);
        chk("abort best_err kept", best_err, 10);
        chk("abort iter_count kept", iter_count, 0);
        chk("abort save_cycles", save_cnt - s_save, 2);
        repeat (4) @(negedge clk);
        chk("abort no_done", done_cnt - s_done, 0);
        err_stim = '{34'd3, 34'd8};
        run_solve(16'd2, "after_abort");
    endtask

    task automatic test_reset_mid();
        int s_done = done_cnt;
        do_start(16'd3);
        do_init();
        wait_state(ST_WAIT, "rst_mid");
        send_err(34'd10);
        wait_state(ST_READ, "rst_mid");
        chk("rst_mid pre best_err", best_err, 10);
        chk("rst_mid pre iter_count", iter_count, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid async state", dbg_state, ST_IDLE);
        chk("rst_mid async strobes", {mem_wr_en, mem_rd_en, mem_update, mem_init_flag}, 0);
        chk("rst_mid async status", {busy, done, converged}, 0);
        chk("rst_mid async best_err", best_err, {EW{1'b1}});
        chk("rst_mid async iter_count", iter_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_err(34'd3);
        repeat (4) @(negedge clk);
        chk("idle err ignored best_err", best_err, {EW{1'b1}});
        chk("idle err ignored state", dbg_state, ST_IDLE);
        chk("rst_mid no_done", done_cnt - s_done, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_converge();
        test_equal();
        test_max_zero();
        test_abort();
        test_reset_mid();
        test_basic();
        chk("strobe overlap cycles", overlap_cnt, 0);
        chk("scoreboard left", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/best_weight_ctrl.md
BEST_WEIGHT_CTRL -- requirements
Module: best_weight_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning width of one weight/root word.
REQ-002 The block SHALL have parameter EXTRA_BITS, default 2, meaning FloPoCo exception bits; ERR_WIDTH = DATA_WIDTH+EXTRA_BITS.
REQ-003 The block SHALL have parameter NUM_UNKNOWNS, default 4, meaning active unknowns per system (1..RAM_DEPTH).
REQ-004 The block SHALL have parameter RAM_DEPTH, default 8, meaning total weight-memory entries including padding.
REQ-005 The block SHALL have parameter ITER_WIDTH, default 16, meaning iteration counter width.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 start  input  1  one-cycle pulse to begin a solve; ignored unless in IDLE.
REQ-009 abort  input  1  synchronous abort; forces IDLE from any state.
REQ-010 max_iter  input  ITER_WIDTH  iteration limit, sampled on accepted start.
REQ-011 init_valid  input  1  initial-guess word present on memory data_in this cycle.
REQ-012 err_valid  input  1  one-cycle strobe: err_in holds current iteration error.
REQ-013 err_in  input  ERR_WIDTH  unsigned error magnitude of current iteration.
REQ-014 mem_wr_en, mem_rd_en, mem_update, mem_init_flag  output  1 each  drive weight-memory wr_en, rd_en, Update_Weight, local_initial_read_flag.
REQ-015 best_err  output  ERR_WIDTH  smallest error accepted in current solve.
REQ-016 iter_count  output  ITER_WIDTH  completed iterations in current solve.
REQ-017 busy  output  1  high in every state except IDLE; done  output  1  one-cycle completion pulse; converged  output  1  high with done if exit was by zero error.

Function
REQ-018 FSM states SHALL be IDLE, INIT, READ, WAIT_ERR, SAVE, DONE; all outputs registered.
REQ-019 IDLE + start: latch max_iter, clear iter_count, best_err <= all ones, converged <= 0, go INIT.
REQ-020 INIT: mem_init_flag=1, mem_wr_en=init_valid; write counter increments per init_valid; after the RAM_DEPTH-th write go READ, counter cleared.
REQ-021 READ: mem_rd_en=1 for exactly NUM_UNKNOWNS consecutive cycles, then go WAIT_ERR.
REQ-022 WAIT_ERR: hold all memory strobes low until err_valid; err_valid outside WAIT_ERR SHALL be ignored.
REQ-023 On err_valid: if err_in < best_err (unsigned strict), best_err <= err_in and go SAVE; else skip SAVE; equal error SHALL NOT save.
REQ-024 SAVE: mem_update=1 and mem_wr_en=1 for exactly NUM_UNKNOWNS cycles (padding entries never rewritten).
REQ-025 End of iteration (after SAVE, or on non-improving err_valid): iter_count += 1; if err_in == 0 set converged and go DONE; else if new iter_count == max_iter go DONE; else go READ.
REQ-026 max_iter == 0 SHALL be treated as 1 (one iteration always executes).
REQ-027 iter_count SHALL saturate at all ones and never wrap.
REQ-028 DONE: done=1 for one cycle, busy=0 next cycle, return IDLE; best_err, iter_count, converged held until next start.
REQ-029 start while busy SHALL be ignored; start and abort in same cycle: abort wins.
REQ-030 abort: next cycle state IDLE, all memory strobes 0, done not pulsed, best_err/iter_count keep last values.
REQ-031 mem_update and mem_init_flag SHALL never be high in the same cycle; mem_rd_en and mem_wr_en SHALL never be high in the same cycle.

Reset
REQ-032 On rst: state IDLE, all 1-bit outputs 0, iter_count 0, best_err all ones, internal counters 0; effect immediate, independent of clk.
REQ-033 rst asserted mid-solve SHALL abandon the solve; no done pulse after release.

Verification
REQ-034 Defaults, start, 8 init_valid, max_iter=3, errors 10,5,7 -> 8 init writes, 3 READ bursts of 4, SAVE after errs 10 and 5 only, best_err=5, iter_count=3, done once, converged=0.
REQ-035 max_iter=5, errors 9,0 -> SAVE both, converged=1, done after iteration 2, iter_count=2.
REQ-036 Errors 6,6 -> second iteration no SAVE, best_err=6.
REQ-037 abort during SAVE cycle 2 -> next cycle IDLE, strobes low, no done; new start works normally.
REQ-038 rst during READ -> all outputs to reset values asynchronously; err_valid in IDLE ignored.
REQ-039 max_iter=0 -> exactly one iteration, done pulses, iter_count=1.
